imem_program_loader: RTL and testbench

- Writer side of the instruction memory that the multicycle control unit reads: a byte stream is packed into 32-bit little-endian instruction words and written sequentially into instruction memory through IMemWrite.
- Holds the processor (cpu_hold) until the program is fully loaded, then releases it.
- Sits between the host/UART byte source and the instruction memory write port, ahead of the control unit's fetch path.

---
 rtl/imem_program_loader.sv | 143 ++++++++++++++
 tb/tb_imem_program_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them sequentially
// into instruction memory, holding the CPU until the whole program is in place.
module imem_program_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              IMemWrite,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [7:0]        checksum,
    output logic [1:0]        state
);

    // Byte stream handshake: a byte moves on a cycle where rx_valid && rx_ready;
    // rx_ready is high exactly while collecting, and rx_data must be stable with rx_valid.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0] word_idx_q, word_idx_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            imem_write_q, imem_write_d;
    logic [31:0]     imem_addr_q, imem_addr_d;
    logic [31:0]     imem_wdata_q, imem_wdata_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            done_q, done_d;
    logic [7:0]      checksum_q, checksum_d;

    logic [ADDR_W:0] clamped_count;
    logic            start_accept;
    logic            xfer;

    assign clamped_count = (num_words > CAP) ? CAP : num_words;
    assign start_accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign xfer          = rx_valid && (state_q == S_COLLECT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 2'd0;
            word_idx_q   <= '0;
            count_q      <= '0;
            imem_write_q <= 1'b0;
            imem_addr_q  <= 32'd0;
            imem_wdata_q <= 32'd0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            checksum_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            count_q      <= count_d;
            imem_write_q <= imem_write_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            checksum_q   <= checksum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (clamped_count == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (rx_valid && (byte_cnt_q == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = ((word_idx_q + IDX_ONE) == count_q) ? S_DONE : S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        word_idx_d   = word_idx_q;
        count_d      = count_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        checksum_d   = checksum_q;
        // Strobe and status are registered views of the state being entered.
        imem_write_d = (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        cpu_hold_d   = (state_d != S_DONE);

        if (start_accept) begin
            count_d      = clamped_count;
            byte_cnt_d   = 2'd0;
            word_idx_d   = '0;
            checksum_d   = 8'd0;
            imem_addr_d  = 32'd0;
            imem_wdata_d = 32'd0;
        end

        if (xfer) begin
            imem_wdata_d[8*byte_cnt_q +: 8] = rx_data;
            checksum_d = checksum_q + rx_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                imem_addr_d = 32'({word_idx_q, 2'b00});
            end
        end

        if (state_q == S_WRITE) begin
            word_idx_d = word_idx_q + IDX_ONE;
        end
    end

    assign rx_ready   = (state_q == S_COLLECT);
    assign IMemWrite  = imem_write_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign checksum   = checksum_q;
    assign state      = state_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: every memory write is checked against
// an expected {addr, wdata} queue filled when the bytes are driven.
module tb_imem_program_loader;

    localparam int ADDR_W = 6;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              IMemWrite;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic [7:0]        checksum;
    logic [1:0]        state;

    imem_program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .IMemWrite  (IMemWrite),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .checksum   (checksum),
        .state      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          checks;
    int          passes;
    int          wr_cnt;
    logic [31:0] last_addr;
    logic [7:0]  csum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (IMemWrite === 1'b1) begin
            wr_cnt++;
            last_addr = imem_addr;
            if (exp_q.size() == 0) begin
                checks++;
                $error("FAIL write_unexpected: observed addr %0h data %0h expected no write",
                       imem_addr, imem_wdata);
            end else begin
                chk("write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [ADDR_W:0] n);
        num_words = n;
        start     = 1'b1;
        csum      = 8'd0;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        csum     = csum + b;
        tick();
        rx_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int          w0;
    logic [31:0] word;
    logic [31:0] words2 [2];

    initial begin
        checks = 0; passes = 0; wr_cnt = 0; last_addr = 32'd0; csum = 8'd0;
        reset = 1'b1; start = 1'b0; num_words = '0; rx_data = 8'd0; rx_valid = 1'b0;

        // Reset state
        tick(); tick();
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_imemwrite", 64'(IMemWrite), 64'd0);
        chk("reset_addr", 64'(imem_addr), 64'd0);
        chk("reset_checksum", 64'(checksum), 64'd0);
        chk("reset_rx_ready", 64'(rx_ready), 64'd0);
        reset = 1'b0;
        tick();

        // Single word, continuous bytes: write in cycle 5, DONE in cycle 6
        exp_q.push_back({32'h0, 32'h00500013});
        start_load(1);
        chk("single_collect_state", 64'(state), 64'd1);
        chk("single_rx_ready", 64'(rx_ready), 64'd1);
        rx_valid = 1'b1;
        send_byte(8'h13); rx_valid = 1'b1;
        chk("single_no_early_write1", 64'(IMemWrite), 64'd0);
        send_byte(8'h00); rx_valid = 1'b1;
        chk("single_no_early_write2", 64'(IMemWrite), 64'd0);
        send_byte(8'h50); rx_valid = 1'b1;
        chk("single_no_early_write3", 64'(IMemWrite), 64'd0);
        send_byte(8'h00);
        chk("single_write_strobe", 64'(IMemWrite), 64'd1);
        chk("single_write_addr", 64'(imem_addr), 64'd0);
        chk("single_write_data", 64'(imem_wdata), 64'h00500013);
        tick();
        chk("single_done", 64'(done), 64'd1);
        chk("single_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("single_checksum", 64'(checksum), 64'h63);
        chk("single_strobe_off", 64'(IMemWrite), 64'd0);
        chk("single_write_count", 64'(wr_cnt), 64'd1);

        // Two words with a one-cycle gap after every byte
        w0 = wr_cnt;
        words2[0] = 32'h00100093;
        words2[1] = 32'h00208133;
        exp_q.push_back({32'd0, words2[0]});
        exp_q.push_back({32'd4, words2[1]});
        start_load(2);
        chk("two_start_clears_done", 64'(done), 64'd0);
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 4; b++) begin
                word = words2[k];
                send_byte(word[8*b +: 8]);
                tick();
            end
        end
        chk("two_done", 64'(done), 64'd1);
        chk("two_write_count", 64'(wr_cnt - w0), 64'd2);
        chk("two_checksum", 64'(checksum), 64'(csum));

        // Reset mid-load discards the partial word
        w0 = wr_cnt;
        start_load(1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("midrst_checksum", 64'(checksum), 64'd0);
        chk("midrst_no_write", 64'(wr_cnt - w0), 64'd0);
        exp_q.push_back({32'd0, 32'hDEADBEEF});
        start_load(1);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        tick();
        chk("midrst_reload_done", 64'(done), 64'd1);
        chk("midrst_reload_count", 64'(wr_cnt - w0), 64'd1);
        chk("midrst_reload_checksum", 64'(checksum), 64'(csum));

        // Zero count from DONE: straight back to DONE, checksum cleared
        w0 = wr_cnt;
        start_load(0);
        chk("zero_state", 64'(state), 64'd3);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_checksum", 64'(checksum), 64'd0);
        tick();
        chk("zero_no_write", 64'(wr_cnt - w0), 64'd0);

        // Clamp 65 -> 64 words, with a start pulse during COLLECT that must be ignored
        w0 = wr_cnt;
        start_load(65);
        for (int k = 0; k < 64; k++) begin
            word = $urandom;
            exp_q.push_back({32'(k * 4), word});
            for (int b = 0; b < 4; b++) begin
                send_byte(word[8*b +: 8]);
                if (k == 0 && b == 1) begin
                    num_words = 1;
                    start     = 1'b1;
                    tick();
                    start     = 1'b0;
                    chk("ignore_start_state", 64'(state), 64'd1);
                end
            end
            tick();
        end
        chk("clamp_done", 64'(done), 64'd1);
        chk("clamp_write_count", 64'(wr_cnt - w0), 64'd64);
        chk("clamp_last_addr", 64'(last_addr), 64'd252);
        chk("clamp_checksum", 64'(checksum), 64'(csum));
        tick(); tick();
        chk("clamp_no_extra_write", 64'(wr_cnt - w0), 64'd64);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
